// File: rtl/acc8_seq.sv
// acc8_seq: handshaked 8-bit accumulator sequencer (CLR/LOAD/SUB/ADD) with carry/ovf/zero flags.
// Optional build macro ACC8_SAT_EN: unsigned saturation of ADD/SUB results.
module acc8_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] op,
    input  logic [7:0] operand,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] acc,
    output logic       carry,
    output logic       ovf,
    output logic       zero
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    typedef enum logic [1:0] {OP_CLR = 2'b00, OP_LOAD = 2'b01, OP_SUB = 2'b10, OP_ADD = 2'b11} op_t;

    typedef struct packed {
        op_t        op;
        logic [7:0] operand;
    } cmd_t;

    state_t     state, state_nxt;
    cmd_t       cmd;
    logic       accept;
    logic       retire;

    logic [7:0] b_eff;
    logic [8:0] raw;
    logic       raw_ovf;
    logic [7:0] res_acc;
    logic       res_carry;
    logic       res_ovf;

    assign accept = in_valid && in_ready;
    assign retire = out_valid && out_ready;
    assign zero   = (acc == 8'h00);

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = !rst;
                if (accept) state_nxt = EXEC;
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                out_valid = 1'b1;
                if (retire) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // op[0] doubles as the datapath mode bit: subtract is acc + ~B + 1.
    always_comb begin
        b_eff   = cmd.op[0] ? cmd.operand : ~cmd.operand;
        raw     = {1'b0, acc} + {1'b0, b_eff} + {8'h00, ~cmd.op[0]};
        raw_ovf = (acc[7] == b_eff[7]) && (raw[7] != acc[7]);
    end

    always_comb begin
        res_acc   = 8'h00;
        res_carry = 1'b0;
        res_ovf   = 1'b0;
        case (cmd.op)
            OP_CLR:  res_acc = 8'h00;
            OP_LOAD: res_acc = cmd.operand;
            OP_SUB, OP_ADD: begin
                res_carry = raw[8];
                res_ovf   = raw_ovf;
`ifdef ACC8_SAT_EN
                // Flags keep the raw result; only the stored value clamps.
                if (cmd.op == OP_ADD && raw[8])
                    res_acc = 8'hFF;
                else if (cmd.op == OP_SUB && !raw[8])
                    res_acc = 8'h00;
                else
                    res_acc = raw[7:0];
`else
                res_acc = raw[7:0];
`endif
            end
            default: res_acc = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cmd   <= '{op: OP_CLR, operand: 8'h00};
            acc   <= 8'h00;
            carry <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept)
                cmd <= '{op: op_t'(op), operand: operand};
            if (state == EXEC) begin
                acc   <= res_acc;
                carry <= res_carry;
                ovf   <= res_ovf;
            end
        end
    end

endmodule
